hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard/forwarding controller for the 5-stage pipeline, successor to the fixed two-stage hazard unit.
- Generalises execute-stage forwarding to NUM_FWD_STAGES downstream stages and adds a multi-cycle mult/div scoreboard that stalls HI/LO consumers while the mult/div unit is busy.
- Adds a saturating stall-cycle performance counter.
- Sits beside the decode/execute pipeline registers. Drives stall, flush and forwarding-mux selects.

Parameters:
- REG_ADDR_WIDTH, 5, register specifier width.
- NUM_FWD_STAGES, 2, number of forwarding sources. Stage 0 is memory (youngest); the highest index is oldest.
- FWD_SEL_WIDTH, 2, forwarding select width. Must be at least clog2(NUM_FWD_STAGES+1).
- MULT_LATENCY, 4, busy cycles for mult/multu. Must be at least 1.
- DIV_LATENCY, 32, busy cycles for div/divu. Must be at least 1.
- COUNT_WIDTH, 32, stall counter width.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- branch_decode  in  1  branch in decode
- Rs_decode, Rt_decode  in  REG_ADDR_WIDTH each  decode source registers
- uses_HI_LO_decode  in  1  decode instruction reads or writes HI/LO (mfhi, mflo, mthi, mtlo, mult, div)
- muldiv_start_decode  in  1  decode instruction is mult/multu/div/divu
- muldiv_is_div_decode  in  1  1 means div/divu
- Rs_execute, Rt_execute  in  REG_ADDR_WIDTH each  execute source registers
- write_register_execute  in  REG_ADDR_WIDTH  execute destination register
- register_write_execute, memory_to_register_execute  in  1 each  execute-stage controls
- memory_to_register_memory  in  1  load in memory stage
- write_register_stages  in  NUM_FWD_STAGES*REG_ADDR_WIDTH  destination of stage k, at bits [k*W +: W]
- register_write_stages  in  NUM_FWD_STAGES  write enable of stage k
- program_counter_multiplexer_jump_execute  in  1  jump/branch taken
- stall_fetch, stall_decode  out  1 each
- flush_execute_register  out  1
- forward_register_file_output_A_execute, forward_register_file_output_B_execute  out  FWD_SEL_WIDTH each
- forward_register_file_output_A_decode, forward_register_file_output_B_decode  out  1 each
- muldiv_busy  out  1  mult/div in flight
- muldiv_done  out  1  one-cycle pulse on completion
- stall_cycle_count  out  COUNT_WIDTH  saturating count of stalled cycles

Behaviour:
- Execute forwarding A:
  - If Rs_execute is nonzero, find the smallest k with register_write_stages[k] set and write_register_stages[k] equal to Rs_execute; output k+1.
  - Otherwise output 0 (register file).
  - Forwarding B is identical using Rt_execute.
- Decode forwarding A/B: 1 when Rs_decode (resp. Rt_decode) is nonzero, matches stage 0 and register_write_stages[0] is set.
- lwstall: memory_to_register_execute, Rt_execute nonzero, and Rt_execute equals Rs_decode or Rt_decode.
- branchstall: branch_decode and either of:
  - register_write_execute with write_register_execute nonzero and equal to Rs_decode or Rt_decode;
  - memory_to_register_memory with stage 0 destination nonzero and equal to Rs_decode or Rt_decode.
- hilo_stall: uses_HI_LO_decode and state is BUSY.
- Stall and flush outputs:
  - stall_fetch and stall_decode both equal lwstall OR branchstall OR hilo_stall.
  - flush_execute_register equals that stall OR program_counter_multiplexer_jump_execute.
  - Stall and jump in the same cycle: both stall and flush asserted.
- Mult/div FSM, states IDLE and BUSY:
  - Accept occurs in IDLE when muldiv_start_decode is high and stall_decode is low.
  - On accept: load counter with DIV_LATENCY-1 if muldiv_is_div_decode is high, else MULT_LATENCY-1; go to BUSY.
  - In BUSY: decrement each cycle. When counter is 0, go to IDLE and register muldiv_done high for exactly one cycle.
  - Accept at cycle t: muldiv_busy is high for cycles t+1 through t+L. IDLE and muldiv_done are seen at t+L+1.
  - A HI/LO consumer decoded at cycle t+L still stalls and issues at t+L+1.
  - A start while BUSY is stalled through hilo_stall; no queueing.
  - muldiv_busy equals (state is BUSY).
- stall_cycle_count: increments on each cycle with stall_decode high and reset low. Holds at all-ones; no wrap.
- Reset:
  - Registered values: state IDLE, counter 0, muldiv_done 0, stall_cycle_count 0.
  - While reset is high: stall_fetch and stall_decode forced 0, flush_execute_register forced 1.
  - Reset during BUSY aborts the operation; muldiv_busy is 0 in the cycle after reset and no done pulse is produced.
- Forwarding outputs are purely combinational. Stall/flush path is combinational from inputs plus the registered state; no added latency.

Test Plan:
- Stage 1 (writeback) writes r5 and stage 0 (memory) writes r5; Rs_execute=5 -> forward A = 1. Drop stage 0's write -> forward A = 2.
- Rs_execute=0 with stage 0 writing r0 -> forward A = 0. Rt_execute=0 with memory_to_register_execute high and Rs_decode=0 -> no stall.
- Load to r8 in execute, Rt_decode=8 -> stall_fetch, stall_decode and flush all 1 for one cycle; stall_cycle_count goes 0 to 1.
- div accepted at cycle 10 with DIV_LATENCY=32 -> muldiv_busy high for cycles 11..42. mflo in decode stalls through 42. muldiv_done high only at 43; mflo issues at 43.
- mult accepted, then reset asserted mid-BUSY -> busy 0 the cycle after reset, no done pulse, counter cleared. A new mult is accepted immediately after.
- Force a constant stall with COUNT_WIDTH=4 -> count saturates at 15. Jump and lwstall in the same cycle -> flush 1 and stall 1.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: pipeline stall/flush/forwarding control with a mult/div busy scoreboard
module hazard_scoreboard #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int NUM_FWD_STAGES = 2,
   parameter int FWD_SEL_WIDTH  = 2,
   parameter int MULT_LATENCY   = 4,
   parameter int DIV_LATENCY    = 32,
   parameter int COUNT_WIDTH    = 32
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     branch_decode,
   input  logic [REG_ADDR_WIDTH-1:0]                Rs_decode,
   input  logic [REG_ADDR_WIDTH-1:0]                Rt_decode,
   input  logic                                     uses_HI_LO_decode,
   input  logic                                     muldiv_start_decode,
   input  logic                                     muldiv_is_div_decode,
   input  logic [REG_ADDR_WIDTH-1:0]                Rs_execute,
   input  logic [REG_ADDR_WIDTH-1:0]                Rt_execute,
   input  logic [REG_ADDR_WIDTH-1:0]                write_register_execute,
   input  logic                                     register_write_execute,
   input  logic                                     memory_to_register_execute,
   input  logic                                     memory_to_register_memory,
   input  logic [NUM_FWD_STAGES*REG_ADDR_WIDTH-1:0] write_register_stages,
   input  logic [NUM_FWD_STAGES-1:0]                register_write_stages,
   input  logic                                     program_counter_multiplexer_jump_execute,
   output logic                                     stall_fetch,
   output logic                                     stall_decode,
   output logic                                     flush_execute_register,
   output logic [FWD_SEL_WIDTH-1:0]                 forward_register_file_output_A_execute,
   output logic [FWD_SEL_WIDTH-1:0]                 forward_register_file_output_B_execute,
   output logic                                     forward_register_file_output_A_decode,
   output logic                                     forward_register_file_output_B_decode,
   output logic                                     muldiv_busy,
   output logic                                     muldiv_done,
   output logic [COUNT_WIDTH-1:0]                   stall_cycle_count
);
   localparam int MAXL = MULT_LATENCY > DIV_LATENCY ? MULT_LATENCY : DIV_LATENCY;
   localparam int CW   = MAXL > 1 ? $clog2(MAXL) : 1;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                    state, state_next;
   logic [CW-1:0]             count, count_next;
   logic                      done_next;
   logic [REG_ADDR_WIDTH-1:0] wr0;
   logic                      lwstall, branchstall, hilo_stall, stall, accept;

   assign wr0 = write_register_stages[REG_ADDR_WIDTH-1:0];

   // Execute forwarding: scan oldest to youngest so the youngest matching stage wins
   always_comb begin
      forward_register_file_output_A_execute = '0;
      forward_register_file_output_B_execute = '0;
      for (int k = NUM_FWD_STAGES - 1; k >= 0; k--) begin
         if (Rs_execute != '0 && register_write_stages[k] &&
             write_register_stages[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == Rs_execute)
            forward_register_file_output_A_execute = FWD_SEL_WIDTH'(k + 1);
         if (Rt_execute != '0 && register_write_stages[k] &&
             write_register_stages[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH] == Rt_execute)
            forward_register_file_output_B_execute = FWD_SEL_WIDTH'(k + 1);
      end
   end

   assign forward_register_file_output_A_decode = Rs_decode != '0 && register_write_stages[0] && wr0 == Rs_decode;
   assign forward_register_file_output_B_decode = Rt_decode != '0 && register_write_stages[0] && wr0 == Rt_decode;

   assign lwstall = memory_to_register_execute && Rt_execute != '0 &&
                    (Rt_execute == Rs_decode || Rt_execute == Rt_decode);
   assign branchstall = branch_decode &&
      ((register_write_execute && write_register_execute != '0 &&
        (write_register_execute == Rs_decode || write_register_execute == Rt_decode)) ||
       (memory_to_register_memory && wr0 != '0 && (wr0 == Rs_decode || wr0 == Rt_decode)));
   assign hilo_stall = uses_HI_LO_decode && state == BUSY;

   // Reset holds the front end still and flushes execute
   assign stall                  = !reset && (lwstall || branchstall || hilo_stall);
   assign stall_fetch            = stall;
   assign stall_decode           = stall;
   assign flush_execute_register = reset || stall || program_counter_multiplexer_jump_execute;
   assign accept                 = state == IDLE && muldiv_start_decode && !stall;
   assign muldiv_busy            = state == BUSY;

   // Mult/div sequencer: load latency-1 on accept, count down, pulse done on leaving BUSY
   always_comb begin
      state_next = state;
      count_next = count;
      done_next  = 1'b0;
      if (state == IDLE) begin
         if (accept) begin
            state_next = BUSY;
            count_next = muldiv_is_div_decode ? CW'(DIV_LATENCY - 1) : CW'(MULT_LATENCY - 1);
         end
      end else if (count == '0) begin
         state_next = IDLE;
         done_next  = 1'b1;
      end else begin
         count_next = count - CW'(1);
      end
   end

   // Sequencer registers; reset aborts any operation in flight without a done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         count       <= '0;
         muldiv_done <= 1'b0;
      end else begin
         state       <= state_next;
         count       <= count_next;
         muldiv_done <= done_next;
      end
   end

   // Saturating count of cycles in which decode is stalled
   always_ff @(posedge clk) begin
      if (reset)
         stall_cycle_count <= '0;
      else if (stall_decode && stall_cycle_count != '1)
         stall_cycle_count <= stall_cycle_count + COUNT_WIDTH'(1);
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and random stimulus checked through an expected-response queue
module tb_hazard_scoreboard;
   localparam int W  = 5;
   localparam int NS = 2;
   localparam int FW = 2;
   localparam int ML = 4;
   localparam int DL = 32;
   localparam int CNTW = 4;

   typedef struct {
      logic rst, br, hilo, st, isdiv, rwe, m2re, m2rm, jmp;
      logic [W-1:0] rsd, rtd, rse, rte, wre;
      logic [NS*W-1:0] ws;
      logic [NS-1:0] rws;
   } stim_t;

   typedef struct {
      int fa, fb, fda, fdb, sf, sd, fl, busy, done, cnt;
   } exp_t;

   logic clk = 0;
   logic reset, branch_decode, uses_HI_LO_decode, muldiv_start_decode, muldiv_is_div_decode;
   logic [W-1:0] Rs_decode, Rt_decode, Rs_execute, Rt_execute, write_register_execute;
   logic register_write_execute, memory_to_register_execute, memory_to_register_memory;
   logic [NS*W-1:0] write_register_stages;
   logic [NS-1:0] register_write_stages;
   logic program_counter_multiplexer_jump_execute;
   logic stall_fetch, stall_decode, flush_execute_register;
   logic [FW-1:0] fwd_a_e, fwd_b_e;
   logic fwd_a_d, fwd_b_d, muldiv_busy, muldiv_done;
   logic [CNTW-1:0] stall_cycle_count;

   int errors = 0;
   int checks = 0;
   exp_t q[$];
   stim_t s;

   int cyc = 0;
   int busy_end = -1;
   int done_at = -1;
   int cnt_m = 0;

   hazard_scoreboard #(
      .REG_ADDR_WIDTH(W), .NUM_FWD_STAGES(NS), .FWD_SEL_WIDTH(FW),
      .MULT_LATENCY(ML), .DIV_LATENCY(DL), .COUNT_WIDTH(CNTW)
   ) dut (
      .clk(clk), .reset(reset), .branch_decode(branch_decode),
      .Rs_decode(Rs_decode), .Rt_decode(Rt_decode),
      .uses_HI_LO_decode(uses_HI_LO_decode), .muldiv_start_decode(muldiv_start_decode),
      .muldiv_is_div_decode(muldiv_is_div_decode),
      .Rs_execute(Rs_execute), .Rt_execute(Rt_execute),
      .write_register_execute(write_register_execute),
      .register_write_execute(register_write_execute),
      .memory_to_register_execute(memory_to_register_execute),
      .memory_to_register_memory(memory_to_register_memory),
      .write_register_stages(write_register_stages),
      .register_write_stages(register_write_stages),
      .program_counter_multiplexer_jump_execute(program_counter_multiplexer_jump_execute),
      .stall_fetch(stall_fetch), .stall_decode(stall_decode),
      .flush_execute_register(flush_execute_register),
      .forward_register_file_output_A_execute(fwd_a_e),
      .forward_register_file_output_B_execute(fwd_b_e),
      .forward_register_file_output_A_decode(fwd_a_d),
      .forward_register_file_output_B_decode(fwd_b_d),
      .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
      .stall_cycle_count(stall_cycle_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s cycle=%0d got=%0d expected=%0d", n, cyc, act, req);
      end
   endtask

   function automatic int fwd_src(input logic [W-1:0] r, input stim_t t);
      if (r == 0) return 0;
      for (int k = 0; k < NS; k++)
         if (t.rws[k] && t.ws[k*W +: W] == r) return k + 1;
      return 0;
   endfunction

   task automatic clear_stim();
      s = '{default: '0};
   endtask

   task automatic step();
      exp_t e;
      logic bz, lw, brs, hs, stl;
      logic [W-1:0] w0;
      reset = s.rst; branch_decode = s.br; Rs_decode = s.rsd; Rt_decode = s.rtd;
      uses_HI_LO_decode = s.hilo; muldiv_start_decode = s.st; muldiv_is_div_decode = s.isdiv;
      Rs_execute = s.rse; Rt_execute = s.rte; write_register_execute = s.wre;
      register_write_execute = s.rwe; memory_to_register_execute = s.m2re;
      memory_to_register_memory = s.m2rm; write_register_stages = s.ws;
      register_write_stages = s.rws; program_counter_multiplexer_jump_execute = s.jmp;
      w0 = s.ws[W-1:0];
      bz = cyc <= busy_end;
      lw = s.m2re && s.rte != 0 && (s.rte == s.rsd || s.rte == s.rtd);
      brs = s.br && ((s.rwe && s.wre != 0 && (s.wre == s.rsd || s.wre == s.rtd)) ||
                     (s.m2rm && w0 != 0 && (w0 == s.rsd || w0 == s.rtd)));
      hs = s.hilo && bz;
      stl = !s.rst && (lw || brs || hs);
      e.fa = fwd_src(s.rse, s);
      e.fb = fwd_src(s.rte, s);
      e.fda = int'(s.rsd != 0 && s.rws[0] && w0 == s.rsd);
      e.fdb = int'(s.rtd != 0 && s.rws[0] && w0 == s.rtd);
      e.sf = int'(stl);
      e.sd = int'(stl);
      e.fl = int'(s.rst || stl || s.jmp);
      e.busy = int'(bz);
      e.done = int'(cyc == done_at);
      e.cnt = cnt_m;
      q.push_back(e);
      if (s.rst) begin
         busy_end = -1;
         done_at = -1;
         cnt_m = 0;
      end else begin
         if (stl && cnt_m < (1 << CNTW) - 1) cnt_m++;
         if (!bz && s.st && !stl) begin
            busy_end = cyc + (s.isdiv ? DL : ML);
            done_at = busy_end + 1;
         end
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("fwd_a_execute", int'(fwd_a_e), e.fa);
         chk("fwd_b_execute", int'(fwd_b_e), e.fb);
         chk("fwd_a_decode", int'(fwd_a_d), e.fda);
         chk("fwd_b_decode", int'(fwd_b_d), e.fdb);
         chk("stall_fetch", int'(stall_fetch), e.sf);
         chk("stall_decode", int'(stall_decode), e.sd);
         chk("flush_execute", int'(flush_execute_register), e.fl);
         chk("muldiv_busy", int'(muldiv_busy), e.busy);
         chk("muldiv_done", int'(muldiv_done), e.done);
         chk("stall_count", int'(stall_cycle_count), e.cnt);
      end
   end

   initial begin
      clear_stim();
      reset = 1;
      @(posedge clk);
      #1;
      s.rst = 1;
      repeat (3) step();
      clear_stim();
      // youngest of two matching stages wins, then the older one alone
      s.rws = 2'b11; s.ws = {5'd5, 5'd5}; s.rse = 5; s.rte = 5;
      step();
      s.rws = 2'b10;
      step();
      // register zero never forwards or stalls
      clear_stim();
      s.rws = 2'b01; s.rse = 0; s.m2re = 1; s.rte = 0; s.rsd = 0;
      step();
      // load-use on r8
      clear_stim();
      s.m2re = 1; s.rte = 8; s.rtd = 8; s.rws = 2'b01; s.ws = {5'd0, 5'd8}; s.rsd = 8;
      step();
      clear_stim();
      // branch hazards from execute and from a load in memory
      s.br = 1; s.rwe = 1; s.wre = 3; s.rsd = 3;
      step();
      clear_stim();
      s.br = 1; s.m2rm = 1; s.ws = {5'd0, 5'd4}; s.rtd = 4;
      step();
      clear_stim();
      repeat (2) step();
      // div accepted, then mflo waits until completion
      s.st = 1; s.isdiv = 1; s.hilo = 1;
      step();
      s.st = 0; s.isdiv = 0;
      repeat (DL + 3) step();
      // mult aborted by reset, then a fresh mult accepted right after
      clear_stim();
      s.st = 1; s.hilo = 1;
      step();
      clear_stim();
      step();
      s.rst = 1;
      step();
      s.rst = 0; s.st = 1; s.hilo = 1;
      step();
      clear_stim();
      repeat (ML + 3) step();
      // sustained load-use stall saturates the counter; jump overlaps it
      s.m2re = 1; s.rte = 9; s.rsd = 9;
      repeat (20) step();
      s.jmp = 1;
      step();
      clear_stim();
      s.jmp = 1;
      step();
      // random traffic on a small register set to provoke frequent hazards
      for (int i = 0; i < 3000; i++) begin
         s.rst = ($urandom_range(0, 99) < 2);
         s.br = $urandom_range(0, 3) == 0;
         s.rsd = W'($urandom_range(0, 3));
         s.rtd = W'($urandom_range(0, 3));
         s.hilo = $urandom_range(0, 2) == 0;
         s.st = $urandom_range(0, 7) == 0;
         s.isdiv = $urandom_range(0, 3) == 0;
         s.rse = W'($urandom_range(0, 3));
         s.rte = W'($urandom_range(0, 3));
         s.wre = W'($urandom_range(0, 3));
         s.rwe = $urandom_range(0, 1) == 1;
         s.m2re = $urandom_range(0, 4) == 0;
         s.m2rm = $urandom_range(0, 4) == 0;
         s.ws = {W'($urandom_range(0, 3)), W'($urandom_range(0, 3))};
         s.rws = NS'($urandom_range(0, 3));
         s.jmp = $urandom_range(0, 7) == 0;
         step();
      end
      @(negedge clk);
      #1;
      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain left=%0d expected=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
